// File: rtl/preta_tile_feeder_if.sv
// Interface bundle for preta_tile_feeder.
//   slave  : feeder side (accepts rows, presents tiles)
//   master : stream source / tile consumer side
// Signals: in_valid/in_ready/in_row/in_mode/in_last (row stream),
//          out_valid/out_ready/out_tile/out_mode (tile output), tile_count.
// Pixel layout: in_row[col], out_tile[row][col], each A_bits wide.
interface preta_tile_feeder_if #(
  parameter int A_bits = 12,
  parameter int CNT_W  = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [0:3][A_bits-1:0]        in_row;
  logic                          in_mode;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [0:3][0:3][A_bits-1:0]   out_tile;
  logic                          out_mode;
  logic [CNT_W-1:0]              tile_count;

  modport slave (
    input  in_valid, in_row, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_tile, out_mode, tile_count
  );

  modport master (
    output in_valid, in_row, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_tile, out_mode, tile_count
  );
endinterface

// File: rtl/preta_tile_feeder.sv
// preta_tile_feeder: collects a row-serial pixel stream (one 4-pixel row per
// beat) into 4x4 tiles held in a ping-pong buffer and presents each complete
// tile with its rf/de mode bit on a valid/ready output with stable data.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : preta_tile_feeder_if.slave (row input stream, tile output, tile_count)
// Build option: define PRETA_FEED_ZPAD_EN to let in_last terminate a partial
// tile early with zero-filled remaining rows; otherwise in_last is ignored.
module preta_tile_feeder #(
  parameter int A_bits = 12,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  preta_tile_feeder_if.slave   bus
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  typedef logic [0:3][0:3][A_bits-1:0] tile_t;

  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  tile_t            mem_q   [2];
  tile_t            mem_d   [2];
  logic             mode_q  [2];
  logic             mode_d  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic accept;
  logic drain;
  logic tile_done;

  // in_ready depends only on registered bank state, never on out_ready.
  assign bus.in_ready   = (state_q[wr_ptr_q] != ST_FULL);
  assign bus.out_valid  = (state_q[rd_ptr_q] == ST_FULL);
  assign bus.out_tile   = mem_q[rd_ptr_q];
  assign bus.out_mode   = mode_q[rd_ptr_q];
  assign bus.tile_count = count_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;

`ifdef PRETA_FEED_ZPAD_EN
  assign tile_done = (row_cnt_q == 2'd3) || bus.in_last;
`else
  assign tile_done = (row_cnt_q == 2'd3);
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
`endif

  // Accept and drain never target the same bank: the drained bank is FULL,
  // and a FULL bank at wr_ptr blocks accept.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    mode_d    = mode_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_cnt_d = row_cnt_q;
    count_d   = count_q;

    if (accept) begin
      mem_d[wr_ptr_q][row_cnt_q] = bus.in_row;
      if (row_cnt_q == 2'd0) begin
        mode_d[wr_ptr_q]  = bus.in_mode;
        state_d[wr_ptr_q] = ST_FILLING;
      end
      if (tile_done) begin
        state_d[wr_ptr_q] = ST_FULL;
        row_cnt_d         = 2'd0;
        wr_ptr_d          = ~wr_ptr_q;
`ifdef PRETA_FEED_ZPAD_EN
        for (int r = 0; r < 4; r++) begin
          if (r > int'(row_cnt_q)) mem_d[wr_ptr_q][r] = '0;
        end
`endif
      end else begin
        row_cnt_d = row_cnt_q + 2'd1;
      end
    end

    if (drain) begin
      state_d[rd_ptr_q] = ST_EMPTY;
      rd_ptr_d          = ~rd_ptr_q;
      count_d           = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0] <= ST_EMPTY;
      state_q[1] <= ST_EMPTY;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      mode_q[0]  <= 1'b0;
      mode_q[1]  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      row_cnt_q  <= 2'd0;
      count_q    <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      mode_q[0]  <= mode_d[0];
      mode_q[1]  <= mode_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      row_cnt_q  <= row_cnt_d;
      count_q    <= count_d;
    end
  end

endmodule
